// File: rtl/calc_op_sequencer.sv
// Calculator control sequencer: accepts one command at a time, steers the
// one-hot result mux, runs the unit start/done handshake and returns results.
module calc_op_sequencer #(
  parameter logic [15:0] MULTI_MASK = 16'h0018,
  parameter logic [3:0]  DIV_OP     = 4'd4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        unit_start,
  input  logic        unit_done,
  output logic [15:0] hotselect,
  input  logic [31:0] muxout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] acc
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [3:0]  op;
  logic [15:0] cnt;

  assign cmd_ready  = (state == S_IDLE);
  assign unit_start = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESPOND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= 4'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      hotselect <= 16'h0001;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      acc       <= 32'd0;
      cnt       <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            op_a      <= cmd_use_acc ? acc : cmd_a;
            op_b      <= cmd_b;
            hotselect <= 16'h0001 << cmd_op;
            // divide-by-zero never reaches the units
            if (cmd_op == DIV_OP && cmd_b == 32'd0) begin
              rsp_err  <= 1'b1;
              rsp_data <= 32'd0;
              state    <= S_RESPOND;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= MULTI_MASK[op] ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          cnt <= cnt + 16'd1;
          // done on the last counted cycle still wins over the abort
          if (unit_done) begin
            state <= S_CAPTURE;
          end else if (cnt == CNT_LAST) begin
            rsp_err  <= 1'b1;
            rsp_data <= 32'd0;
            state    <= S_RESPOND;
          end
        end
        S_CAPTURE: begin
          rsp_data <= muxout;
          acc      <= muxout;
          rsp_err  <= 1'b0;
          state    <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            cnt   <= 16'd0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed plus random commands checked against
// a latency/result model derived from the command rules.
module tb_calc_op_sequencer;

  localparam logic [15:0] MASK = 16'h0018;
  localparam logic [3:0]  DIVO = 4'd4;
  localparam int          TMO  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_use_acc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        unit_start;
  logic        unit_done;
  logic [15:0] hotselect;
  logic [31:0] muxout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] acc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_acc;

  calc_op_sequencer #(
    .MULTI_MASK(MASK),
    .DIV_OP(DIVO),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .op_a(op_a),
    .op_b(op_b),
    .unit_start(unit_start),
    .unit_done(unit_done),
    .hotselect(hotselect),
    .muxout(muxout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_unit_start", 32'(unit_start), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_hotselect", 32'(hotselect), 32'h0001);
    chk("rst_acc", acc, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
  endtask

  // d: cycle after acceptance (accept cycle = 0) in which unit_done is high
  task automatic do_cmd(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic u,
                        input logic [31:0] mux, input int d,
                        input int stall);
    logic [31:0] exp_a;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_starts;
    int          c;
    int          starts;
    bit          got;
    bit          leak;
    bit          moved;
    logic [31:0] held;
    exp_a = u ? m_acc : a;
    exp_starts = 1;
    if (o == DIVO && b == 32'd0) begin
      exp_lat = 1; exp_err = 1'b1; exp_data = 32'd0; exp_starts = 0;
    end else if (!MASK[o]) begin
      exp_lat = 3; exp_err = 1'b0; exp_data = mux;
    end else if (d >= 2 && d <= TMO + 1) begin
      exp_lat = d + 2; exp_err = 1'b0; exp_data = mux;
    end else begin
      exp_lat = TMO + 2; exp_err = 1'b1; exp_data = 32'd0;
    end
    chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = o;
    cmd_a = a;
    cmd_b = b;
    cmd_use_acc = u;
    muxout = mux;
    step();
    cmd_valid = 1'b0;
    cmd_a = $urandom;
    cmd_b = $urandom;
    cmd_use_acc = 1'b0;
    c = 1; got = 0; starts = 0; leak = 0;
    while (!got && c < 200) begin
      if (unit_start) starts++;
      if (cmd_ready) leak = 1;
      if (rsp_valid) begin
        got = 1;
      end else begin
        unit_done = (c == d);
        step();
        c++;
      end
    end
    unit_done = 1'b0;
    chk("rsp_latency", 32'(c), 32'(exp_lat));
    chk("start_pulses", 32'(starts), 32'(exp_starts));
    chk("cmd_ready_busy", 32'(leak), 32'd0);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("hotselect", 32'(hotselect), 32'(16'h0001 << o));
    chk("op_a", op_a, exp_a);
    chk("op_b", op_b, b);
    if (!exp_err) m_acc = mux;
    chk("acc", acc, m_acc);
    held = rsp_data;
    moved = 0;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!rsp_valid || cmd_ready || rsp_data !== held) moved = 1;
    end
    if (stall > 0) chk("backpressure_hold", 32'(moved), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("after_hs_ready", 32'(cmd_ready), 32'd1);
    chk("after_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] o;
    logic [31:0] b;
    int d;
    bit bad;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_a = 32'd0;
    cmd_b = 32'd0;
    cmd_use_acc = 1'b0;
    unit_done = 1'b0;
    muxout = 32'd0;
    rsp_ready = 1'b0;
    m_acc = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    step();

    do_cmd(4'd0, 32'd5, 32'd7, 1'b0, 32'd12, 1, 0);
    do_cmd(4'd3, 32'h11, 32'h22, 1'b0, 32'h0000_0F00, 6, 0);
    do_cmd(4'd0, 32'd5, 32'd7, 1'b0, 32'd12, 0, 0);
    do_cmd(4'd4, 32'd9, 32'd0, 1'b0, 32'hDEAD_BEEF, 2, 0);
    do_cmd(4'd4, 32'd9, 32'd3, 1'b0, 32'd3, 4, 0);
    do_cmd(4'd3, 32'd1, 32'd2, 1'b0, 32'hAAAA_5555, 0, 0);
    do_cmd(4'd3, 32'd1, 32'd2, 1'b0, 32'h1234_5678, TMO + 1, 0);
    do_cmd(4'd3, 32'd1, 32'd2, 1'b0, 32'h0BAD_0BAD, TMO + 2, 0);
    do_cmd(4'd0, 32'd5, 32'd7, 1'b0, 32'd12, 0, 0);
    do_cmd(4'd1, 32'hFFFF, 32'd4, 1'b1, 32'd48, 0, 10);
    do_cmd(4'd15, 32'd3, 32'd3, 1'b0, 32'h8000_0001, 2, 2);

    for (int n = 0; n < 40; n++) begin
      o = 4'($urandom_range(0, 15));
      b = (o == DIVO && $urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      d = MASK[o] ? $urandom_range(1, TMO + 4) : $urandom_range(0, 3);
      do_cmd(o, $urandom, b, 1'($urandom_range(0, 1)), $urandom, d,
             $urandom_range(0, 3));
    end

    cmd_valid = 1'b1;
    cmd_op = 4'd3;
    cmd_a = 32'h55;
    cmd_b = 32'h66;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = 32'd0;
    chk_reset_state();
    unit_done = 1'b1;
    step();
    unit_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (unit_start || rsp_valid || !cmd_ready) bad = 1;
      step();
    end
    chk("late_done_ignored", 32'(bad), 32'd0);
    do_cmd(4'd2, 32'd8, 32'd9, 1'b0, 32'h0000_00AB, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Control block for the calculator datapath. Accepts one command (opcode, two 32-bit operands) at a time from the host-side command interface. Drives the 16-way one-hot result multiplexer select and the functional-unit start/done handshake, captures the selected 32-bit result into an accumulator, and returns it over a valid/ready response interface. Sits between the host middleware link and the 16 functional units whose outputs feed the result multiplexer.

## Interface
- MULTI_MASK, 16'h0018: bit i set means opcode i is multi-cycle and completes on unit_done; clear means single-cycle.
- DIV_OP, 4'd4: opcode checked for divide-by-zero.
- TIMEOUT, 64: maximum WAIT cycles before abort; range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode, 0..15, equals the result mux input index.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_use_acc  in  1  replace operand A with the current accumulator.
- op_a  out  32  latched operand A to the functional units.
- op_b  out  32  latched operand B to the functional units.
- unit_start  out  1  one-cycle start pulse to the functional units.
- unit_done  in  1  completion from the multi-cycle units.
- hotselect  out  16  one-hot select to the result multiplexer.
- muxout  in  32  selected result from the multiplexer.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  result.
- rsp_err  out  1  error (divide-by-zero or timeout).
- acc  out  32  accumulator, the last good result.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, RESPOND. Encoding is left to the implementation.
- Reset values:
  - State IDLE; cmd_ready 1.
  - op_a, op_b, rsp_data, acc all 0.
  - unit_start, rsp_valid, rsp_err all 0.
  - hotselect 16'h0001.
  - Timeout counter 0.
- IDLE:
  - cmd_ready=1. cmd_ready is 0 in every other state.
  - On cmd_valid, latch op, op_a (acc if cmd_use_acc, else cmd_a) and op_b.
  - If op==DIV_OP and cmd_b==0: go to RESPOND with rsp_err=1 and rsp_data=0. No unit_start is issued and acc is unchanged.
  - Otherwise go to ISSUE.
- ISSUE:
  - unit_start=1 for exactly this cycle.
  - Next state is WAIT if MULTI_MASK[op]=1, else CAPTURE.
- WAIT:
  - Counter increments each cycle.
  - unit_done=1 goes to CAPTURE. unit_done wins if it coincides with counter==TIMEOUT-1.
  - Counter reaching TIMEOUT-1 without unit_done goes to RESPOND with rsp_err=1 and rsp_data=0. acc is unchanged.
  - unit_done is ignored in every state except WAIT.
- CAPTURE: rsp_data←muxout, acc←muxout, rsp_err←0, then go to RESPOND.
- RESPOND:
  - rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On the handshake, go to IDLE and clear the counter.
- hotselect is always exactly one-hot: 1<<latched op. It updates on command acceptance and is held through RESPOND and IDLE, so the multiplexer never sees a zero or multi-hot select.
- op_a and op_b are held constant from acceptance until the next acceptance.
- A mid-operation rst returns all state and outputs to their reset values on the next edge. A pending unit_done is then discarded.

## Timing
- Accept handshake at edge T. Single-cycle op: ISSUE in T+1, CAPTURE in T+2, rsp_valid=1 from T+3.
- Multi-cycle op: unit_done high in WAIT cycle D gives CAPTURE at D+1 and rsp_valid from D+2.
- Divide-by-zero: rsp_valid=1 from T+1.
- Timeout: rsp_valid=1 TIMEOUT+2 cycles after acceptance.
- The next command can be accepted 1 cycle after the response handshake. Throughput is one command per 4 cycles minimum.
- muxout must be valid in the CAPTURE cycle, i.e. combinational from op_a, op_b and hotselect, or held by the unit after done.

## Test plan
- Single-cycle op: op=0, a=5, b=7, muxout=12, rsp_ready=1. Expect hotselect=16'h0001, one unit_start pulse, rsp_valid 3 cycles after accept, rsp_data=12, acc=12, rsp_err=0.
- Multi-cycle op: op=3, unit_done raised 5 cycles after unit_start, muxout=0x0000_0F00. Expect hotselect=16'h0008, rsp_data=0x0F00 two cycles after done, cmd_ready=0 throughout.
- Divide-by-zero: op=4, b=0 with acc=12. Expect no unit_start, rsp_err=1, rsp_data=0, acc stays 12. Then op=4, b=3 gives a normal WAIT/done flow.
- Timeout: op=3, unit_done never asserted, TIMEOUT=64. Expect rsp_err=1 and rsp_data=0 at cycle 66 after accept, acc unchanged. Also: unit_done asserted on the final WAIT cycle produces a good result.
- Accumulator chaining and backpressure: op=0 gives 12, then cmd_use_acc=1. Expect op_a=12. Hold rsp_ready=0 for 10 cycles; rsp_data and rsp_valid stay stable and cmd_ready stays 0.
- Reset mid-WAIT: assert rst for 1 cycle. Expect all outputs at reset values (hotselect=16'h0001, acc=0) the next cycle, and a late unit_done ignored.
